// File: rtl/colector_rr6_if.sv
// Bundle of the six lane inputs and the merged, handshaked output of the lane collector.
// The slave modport is the collector's view; master is the driver/observer side.
interface colector_rr6_if;
  logic [7:0] dataIn0, dataIn1, dataIn2, dataIn3, dataIn4, dataIn5;
  logic       validIn0, validIn1, validIn2, validIn3, validIn4, validIn5;
  logic       ready_out;
  logic       clear_ovf;
  logic [7:0] dataOut;
  logic [2:0] laneOut;
  logic       validOut;
  logic [5:0] full;
  logic [5:0] overflow;

  modport master (
    output dataIn0, dataIn1, dataIn2, dataIn3, dataIn4, dataIn5,
    output validIn0, validIn1, validIn2, validIn3, validIn4, validIn5,
    output ready_out, clear_ovf,
    input  dataOut, laneOut, validOut, full, overflow
  );

  modport slave (
    input  dataIn0, dataIn1, dataIn2, dataIn3, dataIn4, dataIn5,
    input  validIn0, validIn1, validIn2, validIn3, validIn4, validIn5,
    input  ready_out, clear_ovf,
    output dataOut, laneOut, validOut, full, overflow
  );
endinterface

// File: rtl/colector_rr6.sv
// Six-lane byte collector: per-lane FIFOs merged by a round-robin arbiter into one
// valid/ready byte stream tagged with its source lane; bytes hitting a full lane are dropped.
module colector_rr6 #(
  parameter int unsigned DEPTH = 4
) (
  input logic           clk_1,
  input logic           reset,
  colector_rr6_if.slave bus
);

  localparam int unsigned NL = 6;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] DepthCnt = PW'(DEPTH);

  logic [7:0]    din [NL];
  logic [NL-1:0] vin;

  logic [7:0]    mem [NL][DEPTH];
  logic [PW-1:0] wr_q [NL];
  logic [PW-1:0] wr_d [NL];
  logic [PW-1:0] rd_q [NL];
  logic [PW-1:0] rd_d [NL];
  logic [PW-1:0] cnt  [NL];

  logic [NL-1:0] nonempty, is_full, pop, accept, drop;
  logic [NL-1:0] ovf_q, ovf_d;
  logic [2:0]    last_q, last_d, grant, cand;
  logic          any, can_load, load;
  logic [7:0]    head;
  logic [7:0]    data_q, data_d;
  logic [2:0]    lane_q, lane_d;
  logic          valid_q, valid_d;

  assign din[0] = bus.dataIn0;
  assign din[1] = bus.dataIn1;
  assign din[2] = bus.dataIn2;
  assign din[3] = bus.dataIn3;
  assign din[4] = bus.dataIn4;
  assign din[5] = bus.dataIn5;
  assign vin = {bus.validIn5, bus.validIn4, bus.validIn3,
                bus.validIn2, bus.validIn1, bus.validIn0};

  always_comb begin
    for (int unsigned k = 0; k < NL; k++) begin
      cnt[k]      = wr_q[k] - rd_q[k];
      nonempty[k] = (cnt[k] != '0);
      is_full[k]  = (cnt[k] == DepthCnt);
    end
  end

  // Search starts one past the last grant so every busy lane is served within six grants.
  always_comb begin
    grant = last_q;
    cand  = '0;
    any   = 1'b0;
    for (int unsigned i = 1; i <= NL; i++) begin
      cand = 3'((32'(last_q) + i) % NL);
      if (!any && nonempty[cand]) begin
        grant = cand;
        any   = 1'b1;
      end
    end
  end

  assign can_load = !valid_q || bus.ready_out;
  assign load     = can_load && any;
  assign pop      = load ? (NL'(1) << grant) : '0;
  assign head     = mem[grant][rd_q[grant][AW-1:0]];

  // A full lane still takes a byte when it is being popped on the same edge.
  assign accept = vin & (~is_full | pop);
  assign drop   = vin & ~accept;
  assign ovf_d  = (bus.clear_ovf ? '0 : ovf_q) | drop;

  always_comb begin
    for (int unsigned k = 0; k < NL; k++) begin
      wr_d[k] = wr_q[k] + PW'(accept[k]);
      rd_d[k] = rd_q[k] + PW'(pop[k]);
    end
  end

  always_comb begin
    data_d  = data_q;
    lane_d  = lane_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (can_load) begin
      if (any) begin
        data_d  = head;
        lane_d  = grant;
        valid_d = 1'b1;
        last_d  = grant;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_1 or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NL; k++) begin
        wr_q[k] <= '0;
        rd_q[k] <= '0;
      end
      ovf_q   <= '0;
      last_q  <= 3'd5;
      data_q  <= '0;
      lane_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NL; k++) begin
        wr_q[k] <= wr_d[k];
        rd_q[k] <= rd_d[k];
      end
      ovf_q   <= ovf_d;
      last_q  <= last_d;
      data_q  <= data_d;
      lane_q  <= lane_d;
      valid_q <= valid_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is readable.
  always_ff @(posedge clk_1) begin
    for (int unsigned k = 0; k < NL; k++) begin
      if (accept[k]) begin
        mem[k][wr_q[k][AW-1:0]] <= din[k];
      end
    end
  end

  assign bus.dataOut  = data_q;
  assign bus.laneOut  = lane_q;
  assign bus.validOut = valid_q;
  assign bus.full     = is_full;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_colector_rr6.sv
// Directed bench for colector_rr6: expected {lane,byte} pairs are queued as stimulus is
// driven and compared in order as each byte is consumed by the handshake.
module tb_colector_rr6;

  logic clk_1 = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;
  logic [10:0] exp_q [$];

  colector_rr6_if bus ();

  colector_rr6 #(.DEPTH(4)) dut (
    .clk_1 (clk_1),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_1 = ~clk_1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int lane, input logic [7:0] d);
    exp_q.push_back({3'(lane), d});
  endtask

  task automatic set_lane(input int k, input logic [7:0] d, input logic v);
    case (k)
      0: begin bus.dataIn0 = d; bus.validIn0 = v; end
      1: begin bus.dataIn1 = d; bus.validIn1 = v; end
      2: begin bus.dataIn2 = d; bus.validIn2 = v; end
      3: begin bus.dataIn3 = d; bus.validIn3 = v; end
      4: begin bus.dataIn4 = d; bus.validIn4 = v; end
      default: begin bus.dataIn5 = d; bus.validIn5 = v; end
    endcase
  endtask

  task automatic clr_lanes();
    for (int k = 0; k < 6; k++) set_lane(k, 8'h00, 1'b0);
  endtask

  // Called one time unit after an edge; a byte shown with ready high is consumed next edge.
  task automatic tick();
    logic [10:0] e;
    if (bus.validOut === 1'b1 && bus.ready_out === 1'b1) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_underflow: observed lane %0d data 0x%0h, expected no output",
               bus.laneOut, bus.dataOut);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_out", 32'({bus.laneOut, bus.dataOut}), 32'(e));
      end
    end
    @(posedge clk_1);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_lanes();
    bus.ready_out = 1'b0;
    bus.clear_ovf = 1'b0;
    exp_q.delete();
    @(posedge clk_1);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (bus.validOut === 1'b0 && exp_q.size() == 0) break;
      tick();
    end
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_idle", 32'(bus.validOut), 32'd0);
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_lanes();
    bus.ready_out = 1'b0;
    bus.clear_ovf = 1'b0;
    #1;
    do_reset();

    // Reset state
    chk("rst_valid", 32'(bus.validOut), 32'd0);
    chk("rst_data", 32'(bus.dataOut), 32'd0);
    chk("rst_lane", 32'(bus.laneOut), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);

    // 1: single byte on lane 2, visible one edge after it is written
    set_lane(2, 8'hA5, 1'b1);
    tick();
    clr_lanes();
    chk("t1_not_yet", 32'(bus.validOut), 32'd0);
    tick();
    chk("t1_valid", 32'(bus.validOut), 32'd1);
    chk("t1_data", 32'(bus.dataOut), 32'hA5);
    chk("t1_lane", 32'(bus.laneOut), 32'd2);
    push(2, 8'hA5);
    bus.ready_out = 1'b1;
    tick();
    chk("t1_consumed", 32'(bus.validOut), 32'd0);

    // 2: all six lanes at once drain in lane order, one byte per cycle
    do_reset();
    bus.ready_out = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_lane(k, 8'(8'h10 + k), 1'b1);
      push(k, 8'(8'h10 + k));
    end
    tick();
    clr_lanes();
    chk("t2_latency", 32'(bus.validOut), 32'd0);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("t2_stream_valid", 32'(bus.validOut), 32'd1);
      tick();
    end
    chk("t2_end_valid", 32'(bus.validOut), 32'd0);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // 3: overfill lane 0 while stalled; 0x06 and 0x07 are dropped
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      set_lane(0, 8'(i), 1'b1);
      if (i <= 5) push(0, 8'(i));
      tick();
    end
    clr_lanes();
    chk("t3_valid", 32'(bus.validOut), 32'd1);
    chk("t3_data", 32'(bus.dataOut), 32'h01);
    chk("t3_full", 32'(bus.full), 32'h01);
    chk("t3_ovf", 32'(bus.overflow), 32'h01);
    bus.ready_out = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t3_end_valid", 32'(bus.validOut), 32'd0);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("t3_ovf_sticky", 32'(bus.overflow), 32'h01);

    // 4: lanes 0 and 3 streaming together alternate 0,3,0,3 in per-lane order
    do_reset();
    bus.ready_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_lane(0, 8'(8'h20 + i), 1'b1);
      set_lane(3, 8'(8'h40 + i), 1'b1);
      push(0, 8'(8'h20 + i));
      push(3, 8'(8'h40 + i));
      tick();
    end
    clr_lanes();
    drain(16);
    chk("t4_ovf", 32'(bus.overflow), 32'd0);

    // 5: write to a full lane on the edge it is popped; then clear vs. drop precedence
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_lane(1, 8'(8'h31 + i), 1'b1);
      tick();
    end
    clr_lanes();
    chk("t5_full_pre", 32'(bus.full), 32'h02);
    chk("t5_ovf_pre", 32'(bus.overflow), 32'd0);
    chk("t5_head", 32'(bus.dataOut), 32'h31);
    set_lane(1, 8'h36, 1'b1);
    bus.ready_out = 1'b1;
    push(1, 8'h31);
    tick();
    clr_lanes();
    bus.ready_out = 1'b0;
    chk("t5_full_same_edge", 32'(bus.full), 32'h02);
    chk("t5_ovf_same_edge", 32'(bus.overflow), 32'd0);
    chk("t5_next_head", 32'(bus.dataOut), 32'h32);
    for (int i = 0; i < 4; i++) begin
      set_lane(4, 8'(8'h41 + i), 1'b1);
      tick();
    end
    clr_lanes();
    chk("t5_full_l4", 32'(bus.full), 32'h12);
    set_lane(4, 8'h4F, 1'b1);
    tick();
    clr_lanes();
    chk("t5_drop_l4", 32'(bus.overflow), 32'h10);
    bus.clear_ovf = 1'b1;
    tick();
    bus.clear_ovf = 1'b0;
    chk("t5_clear", 32'(bus.overflow), 32'd0);
    bus.clear_ovf = 1'b1;
    set_lane(4, 8'h4E, 1'b1);
    tick();
    clr_lanes();
    bus.clear_ovf = 1'b0;
    chk("t5_set_beats_clear", 32'(bus.overflow), 32'h10);
    push(1, 8'h32); push(4, 8'h41); push(1, 8'h33); push(4, 8'h42); push(1, 8'h34);
    push(4, 8'h43); push(1, 8'h35); push(4, 8'h44); push(1, 8'h36);
    bus.ready_out = 1'b1;
    drain(20);

    // 6: asynchronous reset mid-cycle discards everything buffered
    do_reset();
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 3; k++) set_lane(k, 8'(8'h60 + 8 * k + i), 1'b1);
      tick();
    end
    clr_lanes();
    chk("t6_full_pre", 32'(bus.full), 32'h07);
    chk("t6_ovf_pre", 32'(bus.overflow), 32'h06);
    chk("t6_valid_pre", 32'(bus.validOut), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(bus.validOut), 32'd0);
    chk("t6_async_full", 32'(bus.full), 32'd0);
    chk("t6_async_ovf", 32'(bus.overflow), 32'd0);
    chk("t6_async_data", 32'(bus.dataOut), 32'd0);
    #1;
    reset = 1'b0;
    exp_q.delete();
    bus.ready_out = 1'b1;
    @(posedge clk_1);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t6_stays_idle", 32'(bus.validOut), 32'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/colector_rr6.md
Name: colector_rr6

Overview:
- Downstream consumer of the six byte lanes (data/valid pairs, lanes 0..5) produced by the striping/distribution stage.
- Buffers each lane in its own small FIFO.
- Merges the lanes into one byte stream with a round-robin arbiter. The output uses a valid/ready handshake and tags each byte with its source lane.
- Lanes have no backpressure, so bytes arriving at a full lane are dropped and flagged.

Parameters:
DEPTH, 4, entries per lane FIFO (power of two, >=2)

Ports:
clk_1  input  1  single clock; all state changes on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
dataIn0..dataIn5  input  8 each  lane bytes
validIn0..validIn5  input  1 each  lane byte valid; sampled every rising edge
ready_out  input  1  downstream accepts dataOut this edge when validOut=1
clear_ovf  input  1  synchronous clear of all overflow flags
dataOut  output  8  merged byte (registered)
laneOut  output  3  source lane of dataOut, 0..5 (registered)
validOut  output  1  dataOut/laneOut hold a byte (registered)
full  output  6  bit k=1 when lane k FIFO holds DEPTH entries (from registered counts)
overflow  output  6  sticky, bit k set when a lane-k byte was dropped

Behaviour:
- Reset (async assert, any time): every FIFO emptied (pointers/counts 0). dataOut=0, laneOut=0, validOut=0, overflow=0, arbiter last_grant=5. Reset mid-operation discards all buffered bytes; nothing from before reset is ever emitted.
- Lane FIFO k: pointers log2(DEPTH)+1 bits wide, wrap modulo 2*DEPTH; count = wr-rd.
- Write accept: validInk=1 AND (count_k<DEPTH OR lane k popped this same edge). Simultaneous push+pop on a full lane is accepted and count stays DEPTH.
- Drop: validInk=1 and not accepted -> byte discarded, overflow[k] set on that edge.
- Overflow clear: clear_ovf=1 clears all bits on the edge. If a set and a clear hit the same bit on the same edge, the set wins.
- Output register load condition: load = (validOut=0 OR ready_out=1) AND at least one lane non-empty. Non-empty is judged on pre-edge counts; a byte written on the same edge is not visible.
- Grant: first non-empty lane searching last_grant+1, +2, ... modulo 6.
- On load: dataOut <= FIFO head of the granted lane; laneOut <= grant; validOut <= 1; that lane pops; last_grant <= grant.
- No lane non-empty and (validOut=0 or ready_out=1): validOut <= 0. dataOut and laneOut hold their old values.
- Stall: validOut=1 and ready_out=0 -> dataOut, laneOut and validOut stable, no pop.
- Latency: a byte written on edge N appears with validOut=1 after edge N+1 at the earliest.
- Throughput: one byte per cycle with ready_out held high.
- Fairness: a continuously non-empty lane waits at most 5 grants between its own grants.
- Ordering: per-lane FIFO order preserved; no ordering guarantee across lanes beyond round-robin.
- Lane valid inputs are independent; any subset of the six may be active on the same edge.

Test Plan:
1. Reset, then validIn2=1, dataIn2=0xA5 for one edge -> after the following edge: validOut=1, dataOut=0xA5, laneOut=2. Later it drops to 0 once consumed.
2. ready_out=1; all six lanes valid for one edge with data 0x10..0x15 (lane k = 0x10+k) -> six consecutive cycles of dataOut 0x10..0x15, laneOut 0..5, then validOut=0.
3. DEPTH=4, ready_out=0; lane 0 writes 0x01..0x07 on 7 consecutive edges. Required state after that: validOut=1 with dataOut=0x01, full[0]=1, overflow[0]=1, and 0x06 and 0x07 lost. Then ready_out=1 -> 0x01..0x05 emitted on consecutive cycles, then validOut=0.
4. Lanes 0 and 3 valid every cycle (distinct ascending data), ready_out=1 -> laneOut alternates 0,3,0,3. Each lane's bytes come out in their input order; no overflow.
5. Lane 1 full, ready_out=1, arbiter granting lane 1, with validIn1=1 on that edge -> byte accepted, overflow[1] stays 0, full[1] stays 1. Then clear_ovf coinciding with a drop on lane 4 -> overflow[4]=1 after the edge.
6. Fill lanes 0..2 and hold ready_out=0, then pulse reset mid-cycle -> validOut=0, full=0, overflow=0 immediately. After release, with no new writes, validOut stays 0.
